// File: rtl/ref_clock_gen_if.sv
// ref_clock_gen_if: divided clocks and lock flag driven by ref_clock_gen
interface ref_clock_gen_if;
  logic clkout0;
  logic clkout1;
  logic pll_lock;
  modport master (output clkout0, clkout1, pll_lock);
  modport slave (input clkout0, clkout1, pll_lock);
endinterface

// File: rtl/ref_clock_gen.sv
// ref_clock_gen: integer clock dividers on clkin1 released by a sticky lock after a settling count
module ref_clock_gen #(
  parameter int DIV0 = 2,
  parameter int DIV1 = 4,
  parameter int LOCK_CYCLES = 100
) (
  input  logic            clkin1,
  input  logic            rst_n,
  ref_clock_gen_if.master clk_o
);
  if (DIV0 < 2 || DIV1 < 2 || LOCK_CYCLES < 1) begin : g_bad_param
    $error("ref_clock_gen: illegal parameter value");
  end
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic lock_q, lock_d;
  logic [1:0] out_q;
  always_comb begin
    lock_cnt_d = lock_q ? lock_cnt_q : lock_cnt_q + 1'b1;
    lock_d = lock_q | (lock_cnt_q == LOCK_LAST);
  end
  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      lock_q <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q <= lock_d;
    end
  end
  // phase counters stay at 0 on the lock edge so both outputs rise together on the next one
  for (genvar k = 0; k < 2; k++) begin : g_div
    localparam int D = (k == 0) ? DIV0 : DIV1;
    localparam int W = $clog2(D);
    localparam logic [W-1:0] LAST = W'(D - 1);
    localparam logic [W-1:0] HALF = W'(D / 2);
    logic [W-1:0] cnt_q, cnt_d;
    logic out_d;
    always_comb begin
      cnt_d = !lock_q ? '0 : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      out_d = lock_q && (cnt_q < HALF);
    end
    always_ff @(posedge clkin1 or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        out_q[k] <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q[k] <= out_d;
      end
    end
  end
  assign clk_o.clkout0 = out_q[0];
  assign clk_o.clkout1 = out_q[1];
  assign clk_o.pll_lock = lock_q;
endmodule

// File: tb/tb_ref_clock_gen.sv
// tb_ref_clock_gen: directed checks of lock timing, divider waveforms and async reset for three configurations
module tb_ref_clock_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int rises = 0;
  ref_clock_gen_if ia ();
  ref_clock_gen_if ib ();
  ref_clock_gen_if ic ();
  ref_clock_gen dut_a (.clkin1(clk), .rst_n(rst_n), .clk_o(ia));
  ref_clock_gen #(.DIV0(3), .DIV1(5), .LOCK_CYCLES(4)) dut_b (.clkin1(clk), .rst_n(rst_n), .clk_o(ib));
  ref_clock_gen #(.DIV0(2), .DIV1(4), .LOCK_CYCLES(1)) dut_c (.clkin1(clk), .rst_n(rst_n), .clk_o(ic));
  always #10 clk = ~clk;
  always @(posedge ia.pll_lock) rises++;
  task automatic chk(input string tag, input int n, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %b expected %b", tag, n, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " a.lock"}, 0, ia.pll_lock, 1'b0);
    chk({tag, " a.clk0"}, 0, ia.clkout0, 1'b0);
    chk({tag, " a.clk1"}, 0, ia.clkout1, 1'b0);
    chk({tag, " b.lock"}, 0, ib.pll_lock, 1'b0);
    chk({tag, " b.clk0"}, 0, ib.clkout0, 1'b0);
    chk({tag, " b.clk1"}, 0, ib.clkout1, 1'b0);
    chk({tag, " c.lock"}, 0, ic.pll_lock, 1'b0);
    chk({tag, " c.clk0"}, 0, ic.clkout0, 1'b0);
  endtask
  // edge n counts clkin1 rising edges since rst_n release
  task automatic run(input int cycles);
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      #1;
      chk("a.lock", n, ia.pll_lock, n >= 100);
      chk("a.clk0", n, ia.clkout0, n >= 101 && (n - 101) % 2 == 0);
      chk("a.clk1", n, ia.clkout1, n >= 101 && (n - 101) % 4 < 2);
      chk("b.lock", n, ib.pll_lock, n >= 4);
      chk("b.clk0", n, ib.clkout0, n >= 5 && (n - 5) % 3 == 0);
      chk("b.clk1", n, ib.clkout1, n >= 5 && (n - 5) % 5 < 2);
      chk("c.lock", n, ic.pll_lock, n >= 1);
      chk("c.clk0", n, ic.clkout0, n >= 2 && n % 2 == 0);
      chk("c.clk1", n, ic.clkout1, n >= 2 && (n - 2) % 4 < 2);
    end
  endtask
  initial begin
    #5;
    chk_zero("reset");
    @(posedge clk);
    #1;
    chk_zero("reset edge");
    @(negedge clk);
    rst_n = 1'b1;
    run(160);
    checks++;
    assert (rises == 1) else begin
      errors++;
      $error("FAIL lock_rises observed %0d expected 1", rises);
    end
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    #30;
    chk_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    run(130);
    checks++;
    assert (rises == 2) else begin
      errors++;
      $error("FAIL lock_rises observed %0d expected 2", rises);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
